// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC access sequencer.
// Register addresses are listed in sweep order: sec first, year last.
package rtc_pkg;

    localparam int NUM_REGS = 6;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam logic [7:0] ADDR_SEC   = 8'h21;
    localparam logic [7:0] ADDR_MIN   = 8'h22;
    localparam logic [7:0] ADDR_HOUR  = 8'h23;
    localparam logic [7:0] ADDR_DAY   = 8'h24;
    localparam logic [7:0] ADDR_MONTH = 8'h25;
    localparam logic [7:0] ADDR_YEAR  = 8'h26;

    localparam logic [7:0] ADDR_TBL [NUM_REGS] = '{
        ADDR_SEC, ADDR_MIN, ADDR_HOUR,
        ADDR_DAY, ADDR_MONTH, ADDR_YEAR
    };

    typedef logic [2:0] idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_R,
        ST_ISSUE_W,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE_W
    } state_t;

    function automatic logic [7:0] reg_addr(input idx_t i);
        logic [7:0] a;
        a = ADDR_SEC;
        if (int'(i) < NUM_REGS) a = ADDR_TBL[i];
        return a;
    endfunction

endpackage

// File: rtl/rtc_txn_timer.sv
// Loadable down-counter; o_tc flags the last cycle of a bus transaction wait.
// Saturates at zero so an idle counter never wraps.
module rtc_txn_timer #(
    parameter int unsigned CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= W'(CYCLES);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = i_en && (r_cnt == W'(1));

endmodule

// File: rtl/rtc_access_sequencer.sv
// Serialises RTC bus transactions: periodic six-register read sweeps
// plus one-shot time/date writes, with a captured register bank.
module rtc_access_sequencer
    import rtc_pkg::*;
#(
    parameter int unsigned TXN_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] port_in00,
    output logic [7:0] port_out00,
    output logic [7:0] port_out01,
    output logic [1:0] port_out02,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic [7:0] day,
    output logic [7:0] month,
    output logic [7:0] year,
    output logic       busy,
    output logic       frame_valid,
    output logic       wr_done
);

    localparam idx_t LAST_IDX = idx_t'(NUM_REGS - 1);

    state_t     r_state;
    state_t     w_next;
    idx_t       r_idx;
    idx_t       w_idx_next;
    logic       r_rpend;
    logic       r_wpend;
    logic [7:0] r_waddr;
    logic [7:0] r_wdata;
    logic [7:0] r_out_addr;
    logic [7:0] r_out_data;
    logic       r_out_op;
    logic [7:0] r_bank [NUM_REGS];
    logic       w_load;
    logic       w_en;
    logic       w_tc;
    logic       w_go_r;
    logic       w_go_w;

    rtc_txn_timer #(
        .CYCLES (TXN_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_en   (w_en),
        .o_tc   (w_tc)
    );

    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        w_load     = 1'b0;
        w_en       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_wpend) begin
                    w_next = ST_ISSUE_W;
                end else if (r_rpend) begin
                    w_next     = ST_ISSUE_R;
                    w_idx_next = '0;
                end
            end
            ST_ISSUE_R, ST_ISSUE_W: begin
                w_load = 1'b1;
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_en = 1'b1;
                if (w_tc) begin
                    w_next = (r_out_op == OP_WRITE) ? ST_DONE_W : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (r_idx == LAST_IDX) begin
                    w_next = ST_IDLE;
                end else begin
                    w_idx_next = r_idx + 3'd1;
                    w_next     = ST_ISSUE_R;
                end
            end
            ST_DONE_W: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_go_r = (w_next == ST_ISSUE_R);
    assign w_go_w = (w_next == ST_ISSUE_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
        end
    end

    // A request arriving on the issue edge re-arms the flag rather than being lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rpend <= 1'b0;
            r_wpend <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_rpend <= tick | (r_rpend & ~(w_go_r && (r_state == ST_IDLE)));
            r_wpend <= wr_req | (r_wpend & ~w_go_w);
            if (wr_req) begin
                r_waddr <= wr_addr;
                r_wdata <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_addr <= '0;
            r_out_data <= '0;
            r_out_op   <= OP_READ;
        end else if (w_go_w) begin
            r_out_addr <= r_waddr;
            r_out_data <= r_wdata;
            r_out_op   <= OP_WRITE;
        end else if (w_go_r) begin
            r_out_addr <= reg_addr(w_idx_next);
            r_out_op   <= OP_READ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_bank[k] <= '0;
            end
        end else if (r_state == ST_CAPTURE) begin
            r_bank[r_idx] <= port_in00;
        end
    end

    assign port_out00  = r_out_data;
    assign port_out01  = r_out_addr;
    assign port_out02  = {r_out_op,
                          (r_state == ST_ISSUE_R) || (r_state == ST_ISSUE_W)};
    assign sec         = r_bank[0];
    assign min         = r_bank[1];
    assign hour        = r_bank[2];
    assign day         = r_bank[3];
    assign month       = r_bank[4];
    assign year        = r_bank[5];
    assign busy        = (r_state != ST_IDLE) | r_rpend | r_wpend;
    assign frame_valid = (r_state == ST_CAPTURE) && (r_idx == LAST_IDX);
    assign wr_done     = (r_state == ST_DONE_W);

endmodule

// File: tb/tb_rtc_access_sequencer.sv
// Bench for rtc_access_sequencer: table vectors, corner sequences and
// random traffic checked against a transaction-level schedule model.
module tb_rtc_access_sequencer;

    localparam int T  = 8;
    localparam int SW = 6 * (T + 2);

    logic       clk;
    logic       reset;
    logic       tick;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] port_in00;
    logic [7:0] port_out00;
    logic [7:0] port_out01;
    logic [1:0] port_out02;
    logic [7:0] sec, min, hour, day, month, year;
    logic       busy;
    logic       frame_valid;
    logic       wr_done;

    rtc_access_sequencer #(.TXN_CYCLES(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .port_in00   (port_in00),
        .port_out00  (port_out00),
        .port_out01  (port_out01),
        .port_out02  (port_out02),
        .sec         (sec),
        .min         (min),
        .hour        (hour),
        .day         (day),
        .month       (month),
        .year        (year),
        .busy        (busy),
        .frame_valid (frame_valid),
        .wr_done     (wr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int n       = 0;

    // Schedule model: expected transactions keyed by cycle number.
    typedef struct {
        int          cyc;
        logic [47:0] v;
    } bank_chk_t;

    logic [16:0] exp_i    [int];
    logic [16:0] exp_hold [int];
    bit          exp_fv   [int];
    bit          exp_wd   [int];
    bank_chk_t   q_bank   [$];
    int          m_free = 0;
    bit          m_rp = 0;
    bit          m_wp = 0;
    logic [7:0]  m_wa, m_wd;
    logic [7:0]  mmem    [256];
    logic [7:0]  ctl_mem [256];

    int cnt_i, cnt_fv, cnt_wd;
    int first_fv, first_wd, first_wi, first_i, busy_low;
    logic [7:0] first_i_addr;

    typedef struct {
        bit          tk;
        bit          wr;
        logic [7:0]  a;
        logic [7:0]  d;
        int          n_i;
        int          n_fv;
        int          n_wd;
        int          fv_lat;
        int          wd_lat;
        logic [47:0] regs;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, n, act, exp);
        end
    endtask

    task automatic add_txn(input int t, input logic op,
                           input logic [7:0] a, input logic [7:0] d);
        exp_i[t] = {op, a, d};
        for (int c = t; c <= t + T; c++) exp_hold[c] = {op, a, d};
    endtask

    task automatic check_cycle();
        logic [16:0] e;
        bit has;
        has = exp_i.exists(n);
        chk("io_pulse", port_out02[0], has);
        if (exp_hold.exists(n)) begin
            e = exp_hold[n];
            chk("addr", port_out01, e[15:8]);
            chk("op", port_out02[1], e[16]);
            if (e[16]) chk("wdata", port_out00, e[7:0]);
        end
        if (has) begin
            e = exp_i[n];
            if (e[16]) mmem[e[15:8]] = e[7:0];
        end
        chk("frame_valid", frame_valid, exp_fv.exists(n));
        chk("wr_done", wr_done, exp_wd.exists(n));
        chk("busy", busy, (n < m_free) || m_rp || m_wp);
        if (q_bank.size() > 0 && q_bank[0].cyc == n) begin
            chk("bank", {sec, min, hour, day, month, year}, q_bank[0].v);
            void'(q_bank.pop_front());
        end
        if (port_out02[0]) begin
            cnt_i++;
            if (first_i < 0) begin
                first_i = n;
                first_i_addr = port_out01;
            end
            if (port_out02[1] && first_wi < 0) first_wi = n;
            if (port_out02[1]) ctl_mem[port_out01] = port_out00;
            port_in00 = ctl_mem[port_out01];
        end
        if (frame_valid) begin
            cnt_fv++;
            if (first_fv < 0) first_fv = n;
        end
        if (wr_done) begin
            cnt_wd++;
            if (first_wd < 0) first_wd = n;
        end
        if (!busy) busy_low++;
        exp_i.delete(n);
        exp_hold.delete(n);
        exp_fv.delete(n);
        exp_wd.delete(n);
    endtask

    task automatic model_step();
        bank_chk_t b;
        if (reset) begin
            m_rp = 0;
            m_wp = 0;
            m_free = n + 1;
            exp_i.delete();
            exp_hold.delete();
            exp_fv.delete();
            exp_wd.delete();
            q_bank.delete();
            b.cyc = n + 1;
            b.v = '0;
            q_bank.push_back(b);
            return;
        end
        if (n >= m_free && (m_wp || m_rp)) begin
            if (m_wp) begin
                add_txn(n + 1, 1'b1, m_wa, m_wd);
                exp_wd[n + T + 2] = 1;
                m_free = n + T + 3;
                m_wp = 0;
            end else begin
                for (int k = 0; k < 6; k++)
                    add_txn(n + 1 + k * (T + 2), 1'b0, 8'(8'h21 + k), 8'h00);
                exp_fv[n + SW] = 1;
                b.cyc = n + SW + 1;
                b.v = {mmem[8'h21], mmem[8'h22], mmem[8'h23],
                       mmem[8'h24], mmem[8'h25], mmem[8'h26]};
                q_bank.push_back(b);
                m_free = n + 1 + SW;
                m_rp = 0;
            end
        end
        if (tick) m_rp = 1;
        if (wr_req) begin
            m_wp = 1;
            m_wa = wr_addr;
            m_wd = wr_data;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_cycle();
        model_step();
        n++;
        @(posedge clk);
        #1;
        tick = 1'b0;
        wr_req = 1'b0;
    endtask

    task automatic clr_stats();
        cnt_i = 0;
        cnt_fv = 0;
        cnt_wd = 0;
        first_fv = -1;
        first_wd = -1;
        first_wi = -1;
        first_i = -1;
        first_i_addr = '0;
        busy_low = 0;
    endtask

    initial begin
        int c;
        vecs[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 6, 1, 0, 61, -1,
                    48'h10_11_12_13_14_15};
        vecs[1] = '{1'b0, 1'b1, 8'h23, 8'h12, 1, 0, 1, -1, 11,
                    48'h10_11_12_13_14_15};
        vecs[2] = '{1'b1, 1'b1, 8'h24, 8'h31, 7, 1, 1, 72, 11,
                    48'h10_11_12_31_14_15};

        for (int a = 0; a < 256; a++) begin
            mmem[a] = 8'h00;
            ctl_mem[a] = 8'h00;
        end
        for (int k = 0; k < 6; k++) begin
            mmem[8'h21 + k] = 8'(8'h10 + k);
            ctl_mem[8'h21 + k] = 8'(8'h10 + k);
        end
        reset = 1'b1;
        tick = 1'b0;
        wr_req = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        port_in00 = '0;
        clr_stats();
        @(posedge clk);
        #1;
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_ports", {port_out00, port_out01, port_out02}, '0);
        chk("rst_regs", {sec, min, hour, day, month, year}, '0);
        chk("rst_flags", {busy, frame_valid, wr_done}, '0);

        for (int i = 0; i < 3; i++) begin
            clr_stats();
            c = n;
            tick = vecs[i].tk;
            wr_req = vecs[i].wr;
            wr_addr = vecs[i].a;
            wr_data = vecs[i].d;
            cyc();
            repeat (149) cyc();
            chk("v_pulses", cnt_i, vecs[i].n_i);
            chk("v_frames", cnt_fv, vecs[i].n_fv);
            chk("v_wrdone", cnt_wd, vecs[i].n_wd);
            if (vecs[i].fv_lat >= 0) chk("v_fv_lat", first_fv - c, vecs[i].fv_lat);
            if (vecs[i].wd_lat >= 0) chk("v_wd_lat", first_wd - c, vecs[i].wd_lat);
            chk("v_regs", {sec, min, hour, day, month, year}, vecs[i].regs);
        end

        // Write arriving during the third read of a sweep.
        clr_stats();
        c = n;
        tick = 1'b1;
        cyc();
        busy_low = 0;
        for (int k = 1; k <= 72; k++) begin
            if (k == 25) begin
                wr_req = 1'b1;
                wr_addr = 8'h25;
                wr_data = 8'h07;
            end
            cyc();
        end
        chk("mid_busy_low", busy_low, 0);
        chk("mid_fv_lat", first_fv - c, 61);
        chk("mid_wi_lat", first_wi - c, 63);
        chk("mid_wd_lat", first_wd - c, 72);
        repeat (20) cyc();

        // Extra ticks during a sweep merge into one more sweep.
        clr_stats();
        tick = 1'b1;
        cyc();
        for (int k = 1; k < 200; k++) begin
            if (k == 5 || k == 20 || k == 40) tick = 1'b1;
            cyc();
        end
        chk("merge_frames", cnt_fv, 2);
        chk("merge_pulses", cnt_i, 12);

        // Reset in the middle of a read wait.
        tick = 1'b1;
        cyc();
        repeat (4) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst_mid_i", port_out02[0], 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_regs", {sec, min, hour, day, month, year}, '0);
        repeat (3) cyc();
        clr_stats();
        c = n;
        tick = 1'b1;
        cyc();
        repeat (15) cyc();
        chk("rst_restart_lat", first_i - c, 2);
        chk("rst_restart_addr", first_i_addr, 8'h21);
        repeat (60) cyc();

        // Random traffic against the schedule model.
        for (int k = 0; k < 2500; k++) begin
            reset = ($urandom_range(1499) == 0);
            tick = ($urandom_range(39) == 0);
            wr_req = ($urandom_range(59) == 0);
            if ($urandom_range(1) == 0)
                wr_addr = 8'(8'h21 + $urandom_range(5));
            else
                wr_addr = 8'($urandom);
            wr_data = 8'($urandom);
            cyc();
        end
        reset = 1'b0;
        repeat (200) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
